// File: rtl/dual_mem_pkg.sv
// Shared definitions for the dual-port memory controller: default widths,
// response FIFO depth and the controller state type.
package dual_mem_pkg;

    localparam int unsigned DATA_W_DEF    = 64;
    localparam int unsigned ADDR_W_DEF    = 10;
    localparam int unsigned RSP_DEPTH_DEF = 4;

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } state_t;

endpackage

// File: rtl/dual_mem_rsp_fifo.sv
// Synchronous response FIFO with occupancy count; push and pop may coincide.
// Storage is not reset; only pointers and count are cleared.
module dual_mem_rsp_fifo #(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [DATA_W-1:0]        push_data,
    input  logic                     pop,
    output logic [DATA_W-1:0]        head,
    output logic                     valid,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] store [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              do_pop;

    assign valid  = (count != '0);
    assign do_pop = pop && valid;
    assign head   = store[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                store[wr_ptr] <= push_data;
                wr_ptr        <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count + CNT_W'(push) - CNT_W'(do_pop);
        end
    end

endmodule

// File: rtl/dual_mem_ctrl.sv
// Initiator-side controller for a registered dual-port memory with a credited
// response FIFO. Define DUAL_MEM_CTRL_INIT_EN to zero-fill the memory after reset.
module dual_mem_ctrl
    import dual_mem_pkg::*;
#(
    parameter int unsigned DATA_W    = DATA_W_DEF,
    parameter int unsigned ADDR_W    = ADDR_W_DEF,
    parameter int unsigned RSP_DEPTH = RSP_DEPTH_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_valid,
    output logic              rd_ready,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              init_done,
    output logic              mem_memory_enable,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_write_address,
    output logic [DATA_W-1:0] mem_data_in,
    output logic              mem_operation_enable,
    output logic              mem_read,
    output logic [ADDR_W-1:0] mem_read_address,
    input  logic [DATA_W-1:0] mem_data_out
);

    localparam int unsigned CNT_W = $clog2(RSP_DEPTH) + 1;

    state_t            state_q;
    state_t            state_d;
    logic              run_q;
    logic              cap_q;
    logic              wr_fire;
    logic              rd_fire;
    logic [CNT_W-1:0]  fifo_count;
    logic [CNT_W-1:0]  inflight;

`ifdef DUAL_MEM_CTRL_INIT_EN
    logic [ADDR_W-1:0] init_addr;
`endif

    // Reads issued but not yet captured: one on the memory pins, one awaiting capture.
    assign inflight  = CNT_W'(mem_read) + CNT_W'(cap_q);
    assign wr_ready  = run_q;
    assign rd_ready  = run_q && ((fifo_count + inflight) < CNT_W'(RSP_DEPTH));
    assign init_done = run_q;
    assign wr_fire   = wr_valid && wr_ready;
    assign rd_fire   = rd_valid && rd_ready;

    always_comb begin
        state_d = state_q;
`ifdef DUAL_MEM_CTRL_INIT_EN
        if (state_q == ST_INIT && init_addr == '1) begin
            state_d = ST_RUN;
        end
`endif
    end

    // run_q keeps the handshakes closed through reset even though RUN is the reset state.
    always_ff @(posedge clk) begin
        if (rst) begin
`ifdef DUAL_MEM_CTRL_INIT_EN
            state_q <= ST_INIT;
`else
            state_q <= ST_RUN;
`endif
            run_q <= 1'b0;
        end else begin
            state_q <= state_d;
            run_q   <= (state_d == ST_RUN);
        end
    end

`ifdef DUAL_MEM_CTRL_INIT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            init_addr <= '0;
        end else if (state_q == ST_INIT) begin
            init_addr <= init_addr + ADDR_W'(1);
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_memory_enable    <= 1'b0;
            mem_write            <= 1'b0;
            mem_write_address    <= '0;
            mem_data_in          <= '0;
            mem_operation_enable <= 1'b0;
            mem_read             <= 1'b0;
            mem_read_address     <= '0;
            cap_q                <= 1'b0;
        end else begin
            cap_q                <= mem_read;
            mem_memory_enable    <= wr_fire;
            mem_write            <= wr_fire;
            mem_operation_enable <= rd_fire;
            mem_read             <= rd_fire;
            if (wr_fire) begin
                mem_write_address <= wr_addr;
                mem_data_in       <= wr_data;
            end
            if (rd_fire) begin
                mem_read_address <= rd_addr;
            end
`ifdef DUAL_MEM_CTRL_INIT_EN
            if (state_q == ST_INIT) begin
                mem_memory_enable <= 1'b1;
                mem_write         <= 1'b1;
                mem_write_address <= init_addr;
                mem_data_in       <= '0;
            end
`endif
        end
    end

    dual_mem_rsp_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (RSP_DEPTH)
    ) u_rsp_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (cap_q),
        .push_data (mem_data_out),
        .pop       (rsp_ready),
        .head      (rsp_data),
        .valid     (rsp_valid),
        .count     (fifo_count)
    );

endmodule

// File: doc/dual_mem_ctrl.md
# dual_mem_ctrl

Initiator-side controller for the 64-bit × 1024-entry dual-port memory. It accepts independent write and read requests over valid/ready handshakes and drives the memory's enable, strobe, address and data pins from registers. It captures the memory's registered read data into a response FIFO that the consumer drains with its own handshake. Optionally, it zero-fills the whole memory after reset before accepting traffic.

## Interface
Parameters:
- DATA_W, 64, data width; must match the memory.
- ADDR_W, 10, address width; memory depth is 2^ADDR_W.
- RSP_DEPTH, 4, response FIFO entries; power of two, minimum 4.

Ports:
- clk  in  1  single clock; all logic on its rising edge.
- rst  in  1  reset; synchronous, active-high.
- wr_valid  in  1  write request valid.
- wr_ready  out  1  write request accepted when wr_valid & wr_ready.
- wr_addr  in  ADDR_W  write address.
- wr_data  in  DATA_W  write data.
- rd_valid  in  1  read request valid.
- rd_ready  out  1  read request accepted when rd_valid & rd_ready.
- rd_addr  in  ADDR_W  read address.
- rsp_valid  out  1  read response available.
- rsp_ready  in  1  consumer takes the response when rsp_valid & rsp_ready.
- rsp_data  out  DATA_W  read response data, FIFO head.
- init_done  out  1  high once the controller is in RUN.
- mem_memory_enable  out  1  to memory write-port enable.
- mem_write  out  1  to memory write strobe.
- mem_write_address  out  ADDR_W  to memory write address.
- mem_data_in  out  DATA_W  to memory write data.
- mem_operation_enable  out  1  to memory read-port enable.
- mem_read  out  1  to memory read strobe.
- mem_read_address  out  ADDR_W  to memory read address.
- mem_data_out  in  DATA_W  from memory; valid one cycle after a read is issued, high-Z otherwise.

## Operation
- States: INIT (present only with the macro) and RUN.
  - Reset enters INIT when the macro is defined, otherwise RUN.
- wr_ready is 1 in RUN and 0 otherwise.
- A write handshake registers mem_memory_enable=mem_write=1, the address and the data for exactly one cycle. Otherwise the strobes are 0 and the address/data hold their last values.
- rd_ready = RUN & (fifo_count + inflight < RSP_DEPTH).
  - inflight (0..2) counts issued reads whose data has not yet been captured.
- A read handshake registers mem_operation_enable=mem_read=1 and the address for one cycle.
  - The next cycle, a capture flag samples mem_data_out into the FIFO. The capture is never dropped, because the credit check guarantees space.
- Write and read handshakes may occur in the same cycle.
  - If they target the same address, the response returns the pre-write contents, matching the memory's semantics. There is no forwarding.
- FIFO: push and pop in the same cycle are both allowed, and the count stays unchanged. rsp_data is stable while rsp_valid & !rsp_ready.
- Responses are returned in request order.

## Timing
- Values during and after reset:
  - wr_ready=0, rd_ready=0, rsp_valid=0, init_done=0.
  - All mem_* strobes and enables are 0; mem addresses and mem_data_in are 0.
  - FIFO and inflight are cleared.
- Reset asserted mid-operation discards in-flight reads and buffered responses. Memory contents are untouched unless INIT re-runs.
- Read latency: handshake at edge E0; memory pins driven after E0; memory samples at E1; capture at E2; rsp_valid high after E2. Minimum latency is 2 cycles.
- Write latency: memory updated at the edge after the handshake edge.
- Sustained throughput is one read and one write per cycle while rsp_ready is held high.
- Without the macro, init_done rises and RUN begins one cycle after rst deasserts.

## Configuration
- DUAL_MEM_CTRL_INIT_EN defined:
  - INIT issues one zero write per cycle to addresses 0..2^ADDR_W-1 using a counter, with wr_ready=rd_ready=0.
  - After the last address is written (1024 cycles at default), the controller enters RUN and init_done rises.
- Not defined: no INIT state and no counter; the memory powers up with undefined contents.

## Structure
- Shared package dual_mem_pkg:
  - DATA_W/ADDR_W defaults.
  - State enum (ST_INIT, ST_RUN).
  - Response FIFO depth constant.
- One sub-module: dual_mem_rsp_fifo, a synchronous FIFO with count output and simultaneous push/pop.

## Test plan
- Write 0xDEAD_BEEF_0000_0001 to address 5, then read address 5 -> rsp_data=0xDEAD_BEEF_0000_0001, rsp_valid 2 cycles after the read handshake.
- Same-cycle write 0x22 and read to address 9, which previously held 0x11 -> response 0x11; a later read returns 0x22.
- rsp_ready=0, issue reads back-to-back -> rd_ready drops after exactly RSP_DEPTH (4) accepts; releasing rsp_ready returns all 4 responses in order.
- Continuous reads to addresses 0..15 and writes to 16..31 with rsp_ready=1 -> one response per cycle with no bubbles.
- Assert rst with 3 responses buffered -> rsp_valid=0 the next cycle and FIFO empty; written data persists (macro undefined).
- With DUAL_MEM_CTRL_INIT_EN: after reset, init_done rises after 1024 cycles; a read of address 1023 returns 0.
